// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   md_op_e    - operation codes presented on the op port (7 is reserved and
//                behaves exactly like OP_NONE).
//   md_state_e - control state of the counter/commit FSM.
//   DEF_*      - default widths and latencies used by the unit's parameters.
//   is_long_op - true for the operations that occupy the unit for several cycles.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  localparam int DEF_CNT_W       = 4;

  function automatic logic is_long_op(input md_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: purely combinational arithmetic core of the multiply/divide unit.
// Ports:
//   op       - operation code (md_op_e encoding)
//   a, b     - rs / rt operands
//   res_hi   - upper product half, or remainder
//   res_lo   - lower product half, or quotient
//   div_zero - a DIV/DIVU with b == 0; the result must not be committed
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  md_op_e             op_e;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               signed_div;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign op_e = md_op_e'(op);

  // Products are formed at double width; sign extension of both operands
  // makes the truncated double-width product the correct signed product.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed division runs on magnitudes with an unsigned divider, then the
  // signs are reapplied. The most-negative dividend keeps its bit pattern as a
  // magnitude (2^(WIDTH-1)), so most-negative / -1 wraps to most-negative with
  // a zero remainder instead of overflowing. A zero divisor is replaced by 1
  // only to keep the divider well defined; that result is never committed.
  assign signed_div = (op_e == OP_DIV);
  assign mag_a      = (signed_div && a[WIDTH-1]) ? -a : a;
  assign mag_b      = (signed_div && b[WIDTH-1]) ? -b : b;
  assign divisor    = (b == '0) ? WIDTH'(1) : mag_b;
  assign quot       = mag_a / divisor;
  assign rem        = mag_a % divisor;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op_e)
      OP_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      OP_DIV: begin
        // Quotient truncates toward zero; remainder follows the dividend sign.
        res_lo   = (a[WIDTH-1] ^ b[WIDTH-1]) ? -quot : quot;
        res_hi   = a[WIDTH-1] ? -rem : rem;
        div_zero = (b == '0);
      end
      OP_DIVU: begin
        res_lo   = quot;
        res_hi   = rem;
        div_zero = (b == '0);
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit holding the architectural HI/LO.
// The result of a long operation is computed in its start cycle and parked in
// pending registers; a countdown models the multi-cycle latency and the
// pending value is copied to HI/LO on the last busy cycle.
// Ports:
//   clk, reset - rising-edge clock, asynchronous active-high reset
//   start      - a valid MD operation is in E this cycle
//   op         - operation code (md_op_e encoding)
//   a, b       - forwarded rs / rt operands
//   busy       - a multi-cycle operation is executing
//   stall_req  - freeze request for the hazard unit
//   hi, lo     - architectural HI / LO, read directly by mfhi/mflo
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_op_e           op_e;
  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             pend_ok_q, pend_ok_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  assign op_e = md_op_e'(op);

  mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op      (op),
    .a       (a),
    .b       (b),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .div_zero(div_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_ok_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_ok_q <= pend_ok_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Starts are only honoured in IDLE; a start seen while BUSY is dropped.
  // pend_ok marks whether the parked result may be committed (false for a
  // divide by zero, which still occupies the unit for the full latency).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_ok_d = pend_ok_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_ok_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYCLES);
              state_d   = ST_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_ok_d = ~div_zero;
              cnt_d     = CNT_W'(DIV_CYCLES);
              state_d   = ST_BUSY;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: begin
            end
          endcase
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_ok_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_BUSY);
  assign stall_req = busy | (start & is_long_op(op_e));
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
